// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states, buffered
// entry layout and the opcode set used to flag illegal instructions.
package instr_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH,
      WAIT,
      DRAIN
   } t_fetch_state;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } t_fetch_entry;

   localparam int unsigned ENTRY_W = $bits(t_fetch_entry);

   localparam logic [6:0] OP_LOAD     = 7'h03;
   localparam logic [6:0] OP_MISC_MEM = 7'h0F;
   localparam logic [6:0] OP_OP_IMM   = 7'h13;
   localparam logic [6:0] OP_AUIPC    = 7'h17;
   localparam logic [6:0] OP_STORE    = 7'h23;
   localparam logic [6:0] OP_OP       = 7'h33;
   localparam logic [6:0] OP_LUI      = 7'h37;
   localparam logic [6:0] OP_BRANCH   = 7'h63;
   localparam logic [6:0] OP_JALR     = 7'h67;
   localparam logic [6:0] OP_JAL      = 7'h6F;
   localparam logic [6:0] OP_SYSTEM   = 7'h73;

   // Compressed encodings (bits [1:0] != 2'b11) are not supported and count as illegal.
   function automatic logic is_illegal(input logic [31:0] instr);
      logic illegal;
      illegal = 1'b1;
      if (instr[1:0] == 2'b11) begin
         case (instr[6:0])
            OP_LOAD, OP_MISC_MEM, OP_OP_IMM, OP_AUIPC, OP_STORE, OP_OP,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: illegal = 1'b0;
            default: illegal = 1'b1;
         endcase
      end
      return illegal;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries; the head is read straight
// from storage registers so consumers never see a path from the memory bus.
module fetch_fifo
   import instr_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         push,
   input  logic [ENTRY_W-1:0]           push_data,
   input  logic                         pop,
   output logic [ENTRY_W-1:0]           head_data,
   output logic                         valid,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]    rd_ptr_q;
   logic [PtrW-1:0]    wr_ptr_q;
   logic [CntW-1:0]    count_q;
   logic               push_ok;
   logic               pop_ok;

   always_comb begin
      push_ok = push && (count_q != CntW'(DEPTH));
      pop_ok  = pop && (count_q != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      head_data = mem_q[rd_ptr_q];
      valid     = (count_q != '0);
      count     = count_q;
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one-outstanding memory requester feeding a small
// buffer toward decode, with redirect flush and stale-response draining.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        if_valid_o,
   input  logic        if_ready_i,
   output logic [31:0] if_instr_o,
   output logic [31:0] if_pc_o,
   output logic        if_illegal_o
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

   t_fetch_state       state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        req_pc_q, req_pc_d;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_valid;
   logic [CntW-1:0]    fifo_count;
   logic [CntW:0]      occupancy;
   t_fetch_entry       push_entry;
   logic [ENTRY_W-1:0] head_bits;
   t_fetch_entry       head;
   logic               unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      req_pc_d  = req_pc_q;
      fifo_push = 1'b0;
      unique case (state_q)
         FETCH: begin
            if (imem_req_o && imem_gnt_i) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + 32'd4;
               // A redirect racing the grant leaves an old-address response in flight.
               state_d  = redirect_i ? DRAIN : WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid_i) begin
               fifo_push = !redirect_i;
               state_d   = FETCH;
            end else if (redirect_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (imem_rvalid_i) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
      if (redirect_i) begin
         pc_d = {redirect_pc_i[31:2], 2'b00};
      end
   end

   always_comb begin
      // Only FETCH can issue, so any other state implies one request in flight.
      occupancy    = {1'b0, fifo_count} + (CntW + 1)'(state_q != FETCH);
      imem_req_o   = rst_n && (state_q == FETCH) && (occupancy < (CntW + 1)'(FIFO_DEPTH));
      imem_addr_o  = pc_q;
      head         = head_bits;
      if_valid_o   = fifo_valid;
      if_instr_o   = head.instr;
      if_pc_o      = head.pc;
      if_illegal_o = fifo_valid && is_illegal(head.instr);
      fifo_pop     = fifo_valid && if_ready_i && !redirect_i;
      push_entry   = '{pc: req_pc_q, instr: imem_rdata_i};
   end

   fetch_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect_i),
      .push     (fifo_push),
      .push_data(push_entry),
      .pop      (fifo_pop),
      .head_data(head_bits),
      .valid    (fifo_valid),
      .count    (fifo_count)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory model with configurable latency and a
// scoreboard of expected decode-side entries and request addresses.
module tb_instr_fetch;

   localparam int unsigned DEPTH = 2;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_illegal;

   int          checks = 0;
   int          failures = 0;
   int          mem_lat = 1;
   logic        gnt_en = 1'b1;
   logic        busy;
   int          cnt;
   logic [31:0] paddr;
   logic        saw_grant = 1'b0;
   exp_t        exp_q[$];
   logic [31:0] addr_q[$];

   instr_fetch #(
      .RESET_PC  (32'h0000_0000),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req_o   (imem_req),
      .imem_addr_o  (imem_addr),
      .imem_gnt_i   (imem_gnt),
      .imem_rvalid_i(imem_rvalid),
      .imem_rdata_i (imem_rdata),
      .redirect_i   (redirect),
      .redirect_pc_i(redirect_pc),
      .if_valid_o   (if_valid),
      .if_ready_i   (if_ready),
      .if_instr_o   (if_instr),
      .if_pc_o      (if_pc),
      .if_illegal_o (if_illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'h0000_0200) return 32'h0000_007F;
      return {a[24:0], 7'h13};
   endfunction

   function automatic logic exp_illegal(input logic [31:0] i);
      if (i[1:0] != 2'b11) return 1'b1;
      case (i[6:0])
         7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73:
            return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   assign imem_gnt = imem_req && gnt_en && !busy;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy        <= 1'b0;
         cnt         <= 0;
         paddr       <= 32'h0;
         imem_rvalid <= 1'b0;
         imem_rdata  <= 32'h0;
      end else begin
         imem_rvalid <= 1'b0;
         if (imem_req && imem_gnt) begin
            if (mem_lat <= 1) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= mem_fn(imem_addr);
            end else begin
               busy  <= 1'b1;
               cnt   <= mem_lat - 1;
               paddr <= imem_addr;
            end
         end else if (busy) begin
            if (cnt == 1) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= mem_fn(paddr);
               busy        <= 1'b0;
            end
            cnt <= cnt - 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] start, input int n);
      logic [31:0] pc;
      for (int i = 0; i < n; i++) begin
         pc = start + 32'(4 * i);
         exp_q.push_back('{pc, mem_fn(pc)});
      end
   endtask

   // Called at a negedge: sets if_ready for the coming edge and scores what that edge transfers.
   task automatic eval();
      exp_t        e;
      logic [31:0] a;
      if_ready = (exp_q.size() != 0);
      if (if_valid && if_ready && !redirect) begin
         e = exp_q.pop_front();
         chk("if_pc", if_pc, e.pc);
         chk("if_instr", if_instr, e.instr);
         chk("if_illegal", 32'(if_illegal), 32'(exp_illegal(e.instr)));
      end
      if (imem_req && imem_gnt) begin
         saw_grant = 1'b1;
         if (addr_q.size() != 0) begin
            a = addr_q.pop_front();
            chk("imem_addr", imem_addr, a);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      eval();
   endtask

   task automatic drain(input string tag);
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) tick();
      chk({tag, "_drained"}, 32'(exp_q.size()), 32'h0);
   endtask

   task automatic redirect_step(input logic [31:0] target, input int n);
      logic [31:0] tgt;
      tgt         = {target[31:2], 2'b00};
      redirect    = 1'b1;
      redirect_pc = target;
      addr_q.delete();
      eval();
      exp_q.delete();
      push_exp(tgt, n);
      addr_q.push_back(tgt);
      addr_q.push_back(tgt + 32'd4);
      @(negedge clk);
      redirect = 1'b0;
      chk("valid_after_redirect", 32'(if_valid), 32'h0);
      eval();
   endtask

   initial begin
      int   nb;
      logic found;
      repeat (3) @(negedge clk);
      chk("reset_req", 32'(imem_req), 32'h0);
      chk("reset_addr", imem_addr, 32'h0);
      chk("reset_valid", 32'(if_valid), 32'h0);
      chk("reset_instr", if_instr, 32'h0);
      chk("reset_pc", if_pc, 32'h0);
      chk("reset_illegal", 32'(if_illegal), 32'h0);

      push_exp(32'h0, 3);
      addr_q.push_back(32'h0);
      addr_q.push_back(32'h4);
      addr_q.push_back(32'h8);
      rst_n = 1'b1;
      #1;
      chk("req_after_reset", 32'(imem_req), 32'h1);
      eval();
      drain("seq");

      repeat (10) tick();
      chk("stall_req", 32'(imem_req), 32'h0);
      chk("stall_valid", 32'(if_valid), 32'h1);
      gnt_en = 1'b0;
      push_exp(32'hC, 4);
      nb = 0;
      for (int i = 0; i < int'(DEPTH) + 2; i++) begin
         @(negedge clk);
         if (if_valid) nb++;
         eval();
      end
      chk("buffered", 32'(nb), 32'(DEPTH));
      gnt_en = 1'b1;
      drain("release");

      mem_lat = 3;
      push_exp(32'h1C, 8);
      saw_grant = 1'b0;
      for (int c = 0; c < 100 && !saw_grant; c++) tick();
      chk("wait_grant_seen", 32'(saw_grant), 32'h1);
      @(negedge clk);
      redirect_step(32'h0000_0102, 3);
      mem_lat = 1;
      drain("redirect_wait");

      push_exp(32'h10C, 6);
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         if (imem_req && imem_gnt) begin
            redirect_step(32'h0000_0200, 3);
            found = 1'b1;
         end else begin
            eval();
         end
      end
      chk("gnt_redirect_seen", 32'(found), 32'h1);
      drain("redirect_gnt");

      @(negedge clk);
      redirect_step(32'hFFFF_FFFC, 3);
      drain("wrap");
      chk("addr_checked", 32'(addr_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: output buffer entries (legal values 2 and 4).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port imem_req_o, output, 1 bit: instruction memory request.
REQ-006 SHALL have port imem_addr_o, output, 32 bits: request address, word-aligned.
REQ-007 SHALL have port imem_gnt_i, input, 1 bit: request accepted this cycle.
REQ-008 SHALL have port imem_rvalid_i, input, 1 bit: response data valid.
REQ-009 SHALL have port imem_rdata_i, input, 32 bits: instruction word.
REQ-010 SHALL have port redirect_i, input, 1 bit: branch/jump redirect from execute.
REQ-011 SHALL have port redirect_pc_i, input, 32 bits: redirect target.
REQ-012 SHALL have port if_valid_o, output, 1 bit: instruction available to decode.
REQ-013 SHALL have port if_ready_i, input, 1 bit: decode accepts the instruction.
REQ-014 SHALL have port if_instr_o, output, 32 bits: instruction word.
REQ-015 SHALL have port if_pc_o, output, 32 bits: PC of if_instr_o.
REQ-016 SHALL have port if_illegal_o, output, 1 bit: opcode bits [6:0] match no package OP_* value, or bits [1:0] != 2'b11.

Function
REQ-017 SHALL limit memory transactions to one outstanding at a time; a response arrives at least 1 cycle after its grant.
REQ-018 SHALL implement FSM states FETCH, WAIT and DRAIN.
REQ-019 FETCH: SHALL assert imem_req_o when FIFO occupancy plus outstanding requests < FIFO_DEPTH; on gnt SHALL go to WAIT, with pc <= pc + 4.
REQ-020 WAIT: on rvalid SHALL push {pc_of_request, rdata} into the FIFO and go to FETCH.
REQ-021 DRAIN: on rvalid SHALL discard the data and go to FETCH.
REQ-022 SHALL hold imem_addr_o stable while imem_req_o=1 and not granted, except on redirect.
REQ-023 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-024 On redirect_i, SHALL load pc with {redirect_pc_i[31:2], 2'b00} and flush all FIFO entries in the same cycle.
REQ-025 Redirect in WAIT without rvalid SHALL go to DRAIN.
REQ-026 Redirect in WAIT with rvalid in the same cycle SHALL discard the data and go to FETCH.
REQ-027 Redirect in FETCH with gnt in the same cycle SHALL go to DRAIN; the granted old-address response is discarded.
REQ-028 Redirect in DRAIN SHALL update pc and stay in DRAIN.
REQ-029 SHALL pop the FIFO when if_valid_o and if_ready_i are both 1; a push and a pop in the same cycle SHALL keep occupancy unchanged.
REQ-030 SHALL drive if_valid_o, if_instr_o, if_pc_o and if_illegal_o from the FIFO head register, with no combinational path from imem_rdata_i.
REQ-031 Redirect SHALL override a same-cycle pop; if_valid_o SHALL be 0 in the cycle after a redirect.
REQ-032 Fetch-to-decode latency SHALL be 1 cycle from rvalid to if_valid_o when the FIFO is empty.

Reset
REQ-033 While rst_n=0, SHALL hold: state=FETCH, pc=RESET_PC, FIFO empty, imem_req_o=0, imem_addr_o=RESET_PC, if_valid_o=0, if_instr_o=0, if_pc_o=0, if_illegal_o=0.
REQ-034 SHALL assert imem_req_o in the first cycle after rst_n deasserts.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction; the memory side SHALL tolerate a response that never completes.

Structure
REQ-036 Shared package SHALL hold: RESET_PC default, t_fetch_state enum (FETCH/WAIT/DRAIN), t_fetch_entry struct (pc, instr), and the opcode list used for illegal detection.
REQ-037 The FIFO SHALL be a sub-module fetch_fifo (parameterised depth, push/pop/flush, count output).

Verification
REQ-038 Reset release, memory with gnt same cycle and rvalid +1 cycle, if_ready_i=1 -> imem_addr_o sequence 0,4,8; if_pc_o 0,4,8 with instructions in order.
REQ-039 if_ready_i=0 for 10 cycles -> exactly FIFO_DEPTH entries buffered, imem_req_o=0, no data lost on release.
REQ-040 Redirect to 32'h0000_0102 while in WAIT -> stale response dropped; next imem_addr_o=32'h0000_0100; next if_pc_o=32'h0000_0100.
REQ-041 Redirect asserted in the same cycle as gnt -> DRAIN entered; the old-address response never appears on if_valid_o.
REQ-042 pc=32'hFFFF_FFFC -> following fetch address 32'h0000_0000.
REQ-043 rdata 32'h0000_0013 -> if_illegal_o=0; rdata 32'h0000_007F -> if_illegal_o=1.
